alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 16-bit ALU between two requesters, e.g. the execute stage and a memory/address-generation unit.
- Each requester issues {op, a, b} over a valid/ready handshake.
- The block grants one requester round-robin, registers the operands, drives the ALU, and captures ALUresult.
- It returns the result to the granted requester over a valid/ready response handshake.

Parameters:
- DATA_W, 16, operand/result width; must match the ALU.
- OP_W, 3, ALU opcode width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  OP_W  requested ALU opcode
- req0_a  in  DATA_W  operand A
- req0_b  in  DATA_W  operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_id  out  1  requester that owns the result (0/1)
- rsp_data  out  DATA_W  captured ALU result
- rsp_err  out  1  opcode was invalid (110/111)
- rsp_ready  in  1  owner consumes the result
- alu_op  out  OP_W  to ALU ALUop
- alu_src_a  out  DATA_W  to ALU srcA
- alu_src_b  out  DATA_W  to ALU srcB
- alu_result  in  DATA_W  from ALU ALUresult (combinational)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, priority pointer=0
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0
  - alu_op=3'b100 (pass), alu_src_a=0, alu_src_b=0
  - reqN_ready=0 while rst_n low
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational: if only one reqN_valid, that requester wins; if both, the one indicated by the priority pointer wins.
  - Only the winner sees reqN_ready=1; the other sees 0.
  - On valid&ready, latch op/a/b/id into operand registers; go to EXEC; pointer moves to the other requester.
  - With no valid, stay in IDLE.
- EXEC, exactly one cycle:
  - alu_op/alu_src_a/alu_src_b are driven from the operand registers.
  - These outputs are registered and stable for the whole cycle.
  - At the end of the cycle, latch alu_result into rsp_data; go to RESP.
  - Invalid op (3'b110, 3'b111): rsp_data=0, rsp_err=1; alu_op is forced to 3'b100 so the ALU never sees X.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_err are held stable until rsp_ready=1.
  - On rsp_ready, clear rsp_valid and return to IDLE.
  - No new request is accepted while in EXEC or RESP; both ready outputs are 0.
- Latency: handshake at edge N → rsp_valid high from cycle N+2 → minimum 3 cycles per operation.
- ALU opcodes:
  - 000 sub, 001 add, 010 lsl, 011 neg, 100 pass A, 101 compare.
  - Compare result: 0 if equal, 1 if A>B, 2 if A<B.
  - Arithmetic wraps modulo 2^16; the block never inspects the result.
- Between operations, alu_* retain the last driven values; no toggling in IDLE.
- Mid-operation reset: everything returns to reset values and the in-flight result is discarded. Requesters must reissue after reset.
- A requester dropping valid before ready is legal; no grant is recorded and the pointer is unchanged.

Decomposition:
- Package alu_pkg holds:
  - DATA_W, OP_W
  - enum alu_op_t: SUB=3'b000, ADD=3'b001, LSL=3'b010, NEG=3'b011, PASS=3'b100, CMP=3'b101
  - enum arb_state_t: IDLE, EXEC, RESP
  - CMP result constants: EQ=0, GT=1, LT=2
- One sub-module, rr_arb2:
  - Two-way round-robin grant with a pointer register.
  - Ports: clk, rst_n, req[1:0], advance, gnt[1:0].

Test Plan:
- After reset, req0 ADD a=5 b=3 → req0_ready same cycle; rsp_valid two cycles later with rsp_id=0, rsp_data=16'h0008, rsp_err=0.
- Both valid back-to-back (req0 SUB 3-5, req1 CMP 7 vs 9) → req0 served first with 16'hFFFE, then req1 with 16'h0002 and rsp_id=1. Next simultaneous pair → req0 served first again (pointer alternates).
- rsp_ready held low 5 cycles after LSL a=1 b=4 → rsp_valid/rsp_data=16'h0010 stable all 5 cycles; req0_ready and req1_ready stay 0 throughout.
- Invalid op 3'b111 from req1 → alu_op=3'b100 during EXEC; response rsp_err=1, rsp_data=0.
- rst_n asserted during EXEC of NEG a=16'h0001 → all outputs immediately at reset values, rsp_valid never rises. After release, a fresh request completes normally with pointer=0.
- Single requester issuing 4 consecutive PASS ops (a=1..4), rsp_ready always 1 → one result every 3 cycles, data 1,2,3,4 in order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// Holds data/opcode widths, ALU opcode and FSM state enums, compare result
// encodings, the request payload struct and an opcode validity helper.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    SUB  = 3'b000,
    ADD  = 3'b001,
    LSL  = 3'b010,
    NEG  = 3'b011,
    PASS = 3'b100,
    CMP  = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Results produced by the ALU for CMP
  localparam logic [DATA_W-1:0] CMP_EQ = DATA_W'(0);
  localparam logic [DATA_W-1:0] CMP_GT = DATA_W'(1);
  localparam logic [DATA_W-1:0] CMP_LT = DATA_W'(2);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

  // Opcodes 110/111 are undefined for the ALU
  function automatic logic op_is_valid(input logic [OP_W-1:0] op);
    return op <= OP_W'(CMP);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two request channels, the response channel and the ALU
// connection. slave: the arbiter side; master: requesters + ALU side.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              rsp_ready;

  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_src_a;
  logic [DATA_W-1:0] alu_src_b;
  logic [DATA_W-1:0] alu_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready, alu_result,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    output alu_op, alu_src_a, alu_src_b
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready, alu_result,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    input  alu_op, alu_src_a, alu_src_b
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports: clk, rst_n, req[1:0] requests, advance (grant was taken),
// gnt[1:0] one-hot combinational grant. Pointer 0 favours req[0].
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  // Grant and next pointer: winner hands priority to the other side
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (advance && (gnt != 2'b00)) ptr_d = gnt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 16-bit ALU between two requesters.
// Ports: clk, rst_n (async active-low), bus (slave modport) carrying both
// request handshakes, the response handshake and the ALU drive/result.
// Flow: IDLE grants and latches operands, EXEC drives the ALU for one
// cycle and captures the result, RESP holds it until rsp_ready.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic              id_q, id_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] src_a_q, src_a_d;
  logic [DATA_W-1:0] src_b_q, src_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0] gnt;
  logic       idle;
  logic       take;
  alu_req_t   sel_req;

  assign idle = (state_q == IDLE);
  // Any grant in IDLE is a handshake since grants only go to valid requesters
  assign take = idle && (gnt != 2'b00);

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .advance (take),
    .gnt     (gnt)
  );

  // Ready is gated by rst_n so no handshake is offered while held in reset
  assign bus.req0_ready = rst_n && idle && gnt[0];
  assign bus.req1_ready = rst_n && idle && gnt[1];

  assign sel_req = gnt[1] ? alu_req_t'{op: bus.req1_op, a: bus.req1_a, b: bus.req1_b}
                          : alu_req_t'{op: bus.req0_op, a: bus.req0_a, b: bus.req0_b};

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    op_d        = op_q;
    alu_op_d    = alu_op_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (take) begin
          id_d     = gnt[1];
          op_d     = sel_req.op;
          // Undefined opcodes are replaced so the ALU only sees legal ops
          alu_op_d = op_is_valid(sel_req.op) ? sel_req.op : OP_W'(PASS);
          src_a_d  = sel_req.a;
          src_b_d  = sel_req.b;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = !op_is_valid(op_q);
        rsp_data_d  = op_is_valid(op_q) ? bus.alu_result : DATA_W'(0);
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      op_q        <= OP_W'(PASS);
      alu_op_q    <= OP_W'(PASS);
      src_a_q     <= '0;
      src_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      op_q        <= op_d;
      alu_op_q    <= alu_op_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.alu_op    = alu_op_q;
  assign bus.alu_src_a = src_a_q;
  assign bus.alu_src_b = src_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
